// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the restoring divider slice.
// Optional divide-by-zero shortcut is selected with DIV_ZERO_DETECT_EN.
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_SUB   = 3'd2,
    S_END   = 3'd3
  } div_state_e;

  localparam int unsigned DEF_W         = 16;
  localparam int unsigned DEF_DONE_HOLD = 32;

  // Bit counter must hold the value W; hold counter must hold DONE_HOLD.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  function automatic int unsigned hold_width(input int unsigned done_hold);
    return $clog2(done_hold + 1);
  endfunction

endpackage

// File: rtl/div_restoring_ctrl.sv
// Sequencer for the restoring divider: FSM, bit counter and done-hold counter.
// div_zero_i is only acted upon when DIV_ZERO_DETECT_EN drives it from the top.
module div_restoring_ctrl
  import div_pkg::*;
#(
  parameter int unsigned W         = DEF_W,
  parameter int unsigned DONE_HOLD = DEF_DONE_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_i,
  input  logic div_zero_i,
  output logic ld_o,
  output logic sh_o,
  output logic sub_o,
  output logic fin_o,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned CNT_W  = cnt_width(W);
  localparam int unsigned HOLD_W = hold_width(DONE_HOLD);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    ld_o    = 1'b0;
    sh_o    = 1'b0;
    sub_o   = 1'b0;
    fin_o   = 1'b0;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (init_i) begin
          ld_o    = 1'b1;
          cnt_d   = CNT_W'(W);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A zero divisor is resolved one edge after the start, with the operands already captured.
        if (div_zero_i) begin
          fin_o   = 1'b1;
          hold_d  = '0;
          state_d = S_END;
        end else begin
          sh_o    = 1'b1;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        sub_o = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          fin_o   = 1'b1;
          hold_d  = '0;
          state_d = S_END;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_END: begin
        done_o = 1'b1;
        if (hold_q == HOLD_W'(DONE_HOLD - 1)) begin
          // Back-to-back: a held init restarts on the very edge that would return to idle.
          if (init_i) begin
            ld_o    = 1'b1;
            cnt_d   = CNT_W'(W);
            state_d = S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/div_restoring_core.sv
// Sequential unsigned restoring divider, one quotient bit per two clocks.
// Define DIV_ZERO_DETECT_EN to short-circuit a zero divisor and raise err.
module div_restoring_core
  import div_pkg::*;
#(
  parameter int unsigned W         = DEF_W,
  parameter int unsigned DONE_HOLD = DEF_DONE_HOLD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         err
);

  logic [W-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic [W-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [W:0]   diff;
  logic         ld, sh, sub, fin, div_zero;

  div_restoring_ctrl #(
    .W         (W),
    .DONE_HOLD (DONE_HOLD)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_i     (init),
    .div_zero_i (div_zero),
    .ld_o       (ld),
    .sh_o       (sh),
    .sub_o      (sub),
    .fin_o      (fin),
    .busy_o     (busy),
    .done_o     (done)
  );

`ifdef DIV_ZERO_DETECT_EN
  logic err_q, err_d;

  assign div_zero = (b_q == '0);
  assign err      = err_q;

  always_comb begin
    err_d = err_q;
    if (ld)
      err_d = 1'b0;
    else if (fin && div_zero)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign div_zero = 1'b0;
  assign err      = 1'b0;
`endif

  assign diff = {1'b0, r_q} - {1'b0, b_q};

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    r_d   = r_q;
    quo_d = quo_q;
    rem_d = rem_q;
    if (ld) begin
      a_d = dividend;
      b_d = divisor;
      r_d = '0;
    end else if (sh) begin
      {r_d, a_d} = {r_q, a_q} << 1;
    end else if (sub) begin
      a_d[0] = ~diff[W];
      if (!diff[W])
        r_d = diff[W-1:0];
    end
    if (fin) begin
      if (div_zero) begin
        quo_d = '1;
        rem_d = a_q;
      end else begin
        quo_d = a_d;
        rem_d = r_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      r_q   <= r_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_div_restoring_core.sv
// Self-checking bench for div_restoring_core: directed table, corner sequences, random ops.
module tb_div_restoring_core;

  localparam int W         = 16;
  localparam int DONE_HOLD = 32;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         init;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  div_restoring_core #(
    .W         (W),
    .DONE_HOLD (DONE_HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division; a zero divisor yields all-ones and the dividend.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output int lat, output bit e);
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    lat = (ZD && b == '0) ? 1 : 2 * W;
    e   = ZD && (b == '0);
  endfunction

  // Called at the negedge following the start edge; lat = edges until done is seen high.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic measure_hold(output int n);
    n = 0;
    while (done && n < 200) begin
      n++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    init     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output int lat, output int hold, output logic e);
    start(a, b);
    wait_done(lat);
    q = quotient;
    r = remainder;
    e = err;
    measure_hold(hold);
  endtask

  initial begin
    vec_t         vecs[8];
    logic [W-1:0] q, r, eq, er;
    logic         e;
    int           lat, hold, elat, ndone;
    bit           ee;
    string        nm;

    vecs[0] = '{16'd100,   16'd7, 16'd14,   16'd2};
    vecs[1] = '{16'hFFFF,  16'd1, 16'hFFFF, 16'd0};
    vecs[2] = '{16'd5,     16'd9, 16'd0,    16'd5};
    vecs[3] = '{16'd0,     16'd3, 16'd0,    16'd0};
    vecs[4] = '{16'd1234,  16'd0, 16'hFFFF, 16'd1234};
    vecs[5] = '{16'd50,    16'd6, 16'd8,    16'd2};
    vecs[6] = '{16'hFFFF,  16'hFFFF, 16'd1, 16'd0};
    vecs[7] = '{16'd40000, 16'd255, 16'd156, 16'd220};

    rst_n = 1'b0; init = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset_quotient",  quotient,  0);
    chk("reset_remainder", remainder, 0);
    chk("reset_busy",      busy,      0);
    chk("reset_done",      done,      0);
    chk("reset_err",       err,       0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1 detail: busy right after the start edge, then latency and hold length.
    dividend = 16'd100; divisor = 16'd7; init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    chk("t1_busy_after_start", busy, 1);
    chk("t1_done_low_early",   done, 0);
    wait_done(lat);
    chk("t1_latency",   lat,       2 * W);
    chk("t1_quotient",  quotient,  14);
    chk("t1_remainder", remainder, 2);
    measure_hold(hold);
    chk("t1_hold",       hold, DONE_HOLD);
    chk("t1_idle_after", busy, 0);

    for (int i = 0; i < 8; i++) begin
      model(vecs[i].dvd, vecs[i].dvs, eq, er, elat, ee);
      run_op(vecs[i].dvd, vecs[i].dvs, q, r, lat, hold, e);
      nm = $sformatf("vec%0d", i);
      chk({nm, "_q"},    q,    vecs[i].q);
      chk({nm, "_r"},    r,    vecs[i].r);
      chk({nm, "_lat"},  lat,  elat);
      chk({nm, "_hold"}, hold, DONE_HOLD);
      chk({nm, "_err"},  e,    ee);
    end

    // T4: asynchronous reset in the middle of an operation.
    start(16'd100, 16'd7);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_quotient_cleared",  quotient,  0);
    chk("t4_remainder_cleared", remainder, 0);
    chk("t4_busy_cleared",      busy,      0);
    chk("t4_done_cleared",      done,      0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("t4_no_result", ndone, 0);
    run_op(16'd200, 16'd13, q, r, lat, hold, e);
    chk("t4_next_q",   q,   15);
    chk("t4_next_r",   r,   5);
    chk("t4_next_lat", lat, 2 * W);

    // T5: init held high across the end of an operation.
    dividend = 16'd50; divisor = 16'd6; init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 16'd81; divisor = 16'd9;
    wait_done(lat);
    chk("t5_first_lat", lat,       2 * W);
    chk("t5_first_q",   quotient,  8);
    chk("t5_first_r",   remainder, 2);
    measure_hold(hold);
    chk("t5_first_hold", hold, DONE_HOLD);
    chk("t5_restart_busy", busy, 1);
    init = 1'b0;
    wait_done(lat);
    chk("t5_second_lat", lat,       2 * W);
    chk("t5_second_q",   quotient,  9);
    chk("t5_second_r",   remainder, 0);
    measure_hold(hold);

    // T6: init and operands toggled while busy must not disturb the running divide.
    start(16'd100, 16'd7);
    for (int k = 0; k < 20; k++) begin
      init     = ~init;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    init = 1'b0;
    wait_done(lat);
    if (lat >= 0) lat = lat + 20;
    chk("t6_latency",   lat,       2 * W);
    chk("t6_quotient",  quotient,  14);
    chk("t6_remainder", remainder, 2);
    measure_hold(hold);
    chk("t6_hold", hold, DONE_HOLD);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = W'($urandom_range(0, 15));
        1:       b = a + W'($urandom_range(0, 3));
        default: b = W'($urandom);
      endcase
      model(a, b, eq, er, elat, ee);
      run_op(a, b, q, r, lat, hold, e);
      chk($sformatf("rand%0d_q_%0d_div_%0d", i, a, b), q,   eq);
      chk($sformatf("rand%0d_r_%0d_div_%0d", i, a, b), r,   er);
      chk($sformatf("rand%0d_lat", i),                lat, elat);
      chk($sformatf("rand%0d_err", i),                e,   ee);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
